// File: rtl/paddle_link_rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pong_link_pkg : shared constants and state encodings for the paddle link
// Revision 1.0
// ----------------------------------------------------------------------------
package pong_link_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         POS_W     = 12;

   typedef enum logic [1:0] {HUNT, GET_HI, GET_LO, GET_CHK} parse_state_t;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP}        rx_state_t;

endpackage
`default_nettype wire

// File: rtl/paddle_link_rx_uart_rx_byte.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_byte : 8N1 byte receiver on an already-synchronized serial line
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_rx_byte
   import pong_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 564
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_sync,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   rx_state_t      state, state_d;
   logic [CW-1:0]  cnt;
   logic [2:0]     bit_idx;
   logic           rx_prev;
   logic           bit_done;
   logic           half_done;

   assign bit_done  = (cnt == CW'(CLKS_PER_BIT - 1));
   assign half_done = (cnt == CW'(CLKS_PER_BIT / 2 - 1));

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (rx_prev && !rx_sync)        state_d = START;
         START:   if (half_done)                  state_d = rx_sync ? IDLE : DATA;
         DATA:    if (bit_done && bit_idx == 3'd7) state_d = STOP;
         STOP:    if (bit_done)                   state_d = IDLE;
         default:                                 state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= 3'd0;
         rx_prev    <= 1'b1;
         data       <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_d;
         rx_prev    <= rx_sync;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         // Counter restarts on every state change, so each phase times from zero
         if (state_d != state)
            cnt <= '0;
         else if (state != IDLE)
            cnt <= bit_done ? '0 : cnt + 1'b1;
         if (state == IDLE)
            bit_idx <= 3'd0;
         if (state == DATA && bit_done) begin
            data    <= {rx_sync, data[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (state == STOP && bit_done) begin
            byte_valid <= rx_sync;
            frame_err  <= !rx_sync;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/paddle_link_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// paddle_link_rx : receives and validates peer paddle position packets
// Revision 1.0
// ----------------------------------------------------------------------------
module paddle_link_rx
   import pong_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 564,
   parameter int BYTE_GAP     = 8192,
   parameter int LINK_TIMEOUT = 6500000,
   parameter int Y_MAX        = 767,
   parameter int Y_RESET      = 384
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   output logic [POS_W-1:0] ypos_sec,
   output logic             ypos_valid,
   output logic             link_ok,
   output logic [7:0]       err_cnt
);

   localparam int GW = $clog2(BYTE_GAP + 1);
   localparam int TW = $clog2(LINK_TIMEOUT + 1);

   logic             rx_meta, rx_sync;
   logic [7:0]       data;
   logic             byte_valid, frame_err;
   parse_state_t     pstate, pstate_d;
   logic [7:0]       hi, lo;
   logic [GW-1:0]    gap_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic             gap_hit, err, accept;
   logic [POS_W-1:0] pos;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx_sync    (rx_sync),
      .data       (data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   assign gap_hit = (gap_cnt == GW'(BYTE_GAP));
   assign pos     = {hi[3:0], lo};

   always_comb begin
      pstate_d = pstate;
      err      = 1'b0;
      accept   = 1'b0;
      if (frame_err) begin
         err      = 1'b1;
         pstate_d = HUNT;
      end else if (byte_valid) begin
         case (pstate)
            HUNT:    if (data == SYNC_BYTE) pstate_d = GET_HI;
            GET_HI:  if (data[7:4] != 4'h0) begin
                        err      = 1'b1;
                        pstate_d = HUNT;
                     end else begin
                        pstate_d = GET_LO;
                     end
            GET_LO:  pstate_d = GET_CHK;
            GET_CHK: begin
                        if (data == (SYNC_BYTE ^ hi ^ lo)) accept = 1'b1;
                        else                               err    = 1'b1;
                        pstate_d = HUNT;
                     end
            default: pstate_d = HUNT;
         endcase
      end else if (pstate != HUNT && gap_hit) begin
         err      = 1'b1;
         pstate_d = HUNT;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pstate     <= HUNT;
         hi         <= 8'h00;
         lo         <= 8'h00;
         gap_cnt    <= '0;
         tmo_cnt    <= '0;
         err_cnt    <= 8'h00;
         ypos_sec   <= POS_W'(Y_RESET);
         ypos_valid <= 1'b0;
         link_ok    <= 1'b0;
      end else begin
         pstate     <= pstate_d;
         ypos_valid <= accept;
         if (byte_valid && pstate == GET_HI) hi <= data;
         if (byte_valid && pstate == GET_LO) lo <= data;
         if (pstate_d == HUNT || byte_valid)
            gap_cnt <= '0;
         else if (!gap_hit)
            gap_cnt <= gap_cnt + 1'b1;
         if (err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
         // Accept wins over timeout; once expired, the reset position is held
         if (accept) begin
            ypos_sec <= (pos > POS_W'(Y_MAX)) ? POS_W'(Y_MAX) : pos;
            link_ok  <= 1'b1;
            tmo_cnt  <= '0;
         end else if (tmo_cnt == TW'(LINK_TIMEOUT)) begin
            ypos_sec <= POS_W'(Y_RESET);
            link_ok  <= 1'b0;
         end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_paddle_link_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_paddle_link_rx : directed self-checking bench for paddle_link_rx
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_paddle_link_rx;

   localparam int CPB  = 16;
   localparam int GAP  = 400;
   localparam int TMO  = 5000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx  = 1'b1;
   logic [11:0] ypos_sec;
   logic        ypos_valid;
   logic        link_ok;
   logic [7:0]  err_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int vcnt     = 0;

   paddle_link_rx #(
      .CLKS_PER_BIT (CPB),
      .BYTE_GAP     (GAP),
      .LINK_TIMEOUT (TMO),
      .Y_MAX        (767),
      .Y_RESET      (384)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .ypos_sec   (ypos_sec),
      .ypos_valid (ypos_valid),
      .link_ok    (link_ok),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   // Counts cycles in which ypos_valid is high
   always @(negedge clk) if (ypos_valid) vcnt++;

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [7:0] v;
      v = b;
      @(negedge clk);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         idle(CPB);
      end
      rx = stop_bit;
      idle(CPB);
      rx = 1'b1;
      idle(4);
   endtask

   task automatic send_pkt(input logic [7:0] b0, b1, b2, b3);
      send_byte(b0, 1'b1);
      send_byte(b1, 1'b1);
      send_byte(b2, 1'b1);
      send_byte(b3, 1'b1);
      idle(4);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      idle(5);
      n_checks++; if (ypos_sec !== 12'd384) begin n_fail++; $display("FAIL reset_ypos: got %0d want 384", ypos_sec); end
      n_checks++; if (link_ok !== 1'b0)     begin n_fail++; $display("FAIL reset_link: got %b want 0", link_ok); end
      n_checks++; if (ypos_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", ypos_valid); end
      rst = 1'b1;
      vcnt = 0;
      idle(3000);
      n_checks++; if (ypos_sec !== 12'd384) begin n_fail++; $display("FAIL idle_ypos: got %0d want 384", ypos_sec); end
      n_checks++; if (link_ok !== 1'b0)     begin n_fail++; $display("FAIL idle_link: got %b want 0", link_ok); end
      n_checks++; if (err_cnt !== 8'd0)     begin n_fail++; $display("FAIL idle_err: got %0d want 0", err_cnt); end
      n_checks++; if (vcnt !== 0)           begin n_fail++; $display("FAIL idle_pulses: got %0d want 0", vcnt); end
   endtask

   task automatic test_accept;
      vcnt = 0;
      send_pkt(8'hA5, 8'h01, 8'h2C, 8'h88);
      n_checks++; if (vcnt !== 1)           begin n_fail++; $display("FAIL accept_pulses: got %0d want 1", vcnt); end
      n_checks++; if (ypos_sec !== 12'd300) begin n_fail++; $display("FAIL accept_ypos: got %0d want 300", ypos_sec); end
      n_checks++; if (link_ok !== 1'b1)     begin n_fail++; $display("FAIL accept_link: got %b want 1", link_ok); end
      n_checks++; if (err_cnt !== 8'd0)     begin n_fail++; $display("FAIL accept_err: got %0d want 0", err_cnt); end
   endtask

   task automatic test_clamp;
      send_pkt(8'hA5, 8'h03, 8'hFF, 8'h59);
      n_checks++; if (ypos_sec !== 12'd767) begin n_fail++; $display("FAIL clamp_ypos: got %0d want 767", ypos_sec); end
      send_pkt(8'hA5, 8'h00, 8'h00, 8'hA5);
      n_checks++; if (ypos_sec !== 12'd0)   begin n_fail++; $display("FAIL zero_ypos: got %0d want 0", ypos_sec); end
   endtask

   task automatic test_bad_packets;
      send_pkt(8'hA5, 8'h01, 8'h2C, 8'h88);
      vcnt = 0;
      send_pkt(8'hA5, 8'h01, 8'h2C, 8'h00);
      send_pkt(8'hA5, 8'h11, 8'h00, 8'hB4);
      n_checks++; if (ypos_sec !== 12'd300) begin n_fail++; $display("FAIL bad_ypos: got %0d want 300", ypos_sec); end
      n_checks++; if (err_cnt !== 8'd2)     begin n_fail++; $display("FAIL bad_err: got %0d want 2", err_cnt); end
      n_checks++; if (vcnt !== 0)           begin n_fail++; $display("FAIL bad_pulses: got %0d want 0", vcnt); end
   endtask

   task automatic test_resync;
      send_byte(8'h7E, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h2C, 1'b1);
      send_byte(8'h88, 1'b1);
      idle(4);
      n_checks++; if (err_cnt !== 8'd3)     begin n_fail++; $display("FAIL resync_err: got %0d want 3", err_cnt); end
      n_checks++; if (ypos_sec !== 12'd300) begin n_fail++; $display("FAIL resync_missed: got %0d want 300", ypos_sec); end
      send_pkt(8'hA5, 8'h00, 8'h64, 8'hC1);
      n_checks++; if (ypos_sec !== 12'd100) begin n_fail++; $display("FAIL resync_ypos: got %0d want 100", ypos_sec); end
   endtask

   task automatic test_gap_timeout;
      vcnt = 0;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      idle(500);
      n_checks++; if (err_cnt !== 8'd4)     begin n_fail++; $display("FAIL gap_err: got %0d want 4", err_cnt); end
      n_checks++; if (link_ok !== 1'b1)     begin n_fail++; $display("FAIL gap_link: got %b want 1", link_ok); end
      idle(TMO);
      n_checks++; if (link_ok !== 1'b0)     begin n_fail++; $display("FAIL tmo_link: got %b want 0", link_ok); end
      n_checks++; if (ypos_sec !== 12'd384) begin n_fail++; $display("FAIL tmo_ypos: got %0d want 384", ypos_sec); end
      n_checks++; if (vcnt !== 0)           begin n_fail++; $display("FAIL tmo_pulses: got %0d want 0", vcnt); end
   endtask

   task automatic test_glitch;
      vcnt = 0;
      @(negedge clk);
      rx = 1'b0;
      idle(6);
      rx = 1'b1;
      idle(200);
      n_checks++; if (err_cnt !== 8'd4)     begin n_fail++; $display("FAIL glitch_err: got %0d want 4", err_cnt); end
      n_checks++; if (vcnt !== 0)           begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", vcnt); end
   endtask

   task automatic test_stop_err;
      send_byte(8'h5A, 1'b0);
      idle(50);
      n_checks++; if (err_cnt !== 8'd5)     begin n_fail++; $display("FAIL stop_err: got %0d want 5", err_cnt); end
   endtask

   task automatic test_reset_mid;
      send_pkt(8'hA5, 8'h00, 8'h64, 8'hC1);
      n_checks++; if (link_ok !== 1'b1)     begin n_fail++; $display("FAIL pre_rst_link: got %b want 1", link_ok); end
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h2C, 1'b1);
      @(negedge clk);
      rx = 1'b0;
      idle(CPB * 3);
      rst = 1'b0;
      rx  = 1'b1;
      #1;
      n_checks++; if (ypos_sec !== 12'd384) begin n_fail++; $display("FAIL midrst_ypos: got %0d want 384", ypos_sec); end
      n_checks++; if (link_ok !== 1'b0)     begin n_fail++; $display("FAIL midrst_link: got %b want 0", link_ok); end
      n_checks++; if (err_cnt !== 8'd0)     begin n_fail++; $display("FAIL midrst_err: got %0d want 0", err_cnt); end
      n_checks++; if (ypos_valid !== 1'b0)  begin n_fail++; $display("FAIL midrst_valid: got %b want 0", ypos_valid); end
      idle(10);
      rst = 1'b1;
      idle(50);
      send_pkt(8'hA5, 8'h00, 8'h64, 8'hC1);
      n_checks++; if (ypos_sec !== 12'd100) begin n_fail++; $display("FAIL post_rst_ypos: got %0d want 100", ypos_sec); end
      n_checks++; if (err_cnt !== 8'd0)     begin n_fail++; $display("FAIL post_rst_err: got %0d want 0", err_cnt); end
   endtask

   initial begin
      test_reset();
      test_accept();
      test_clamp();
      test_bad_packets();
      test_resync();
      test_gap_timeout();
      test_glitch();
      test_stop_err();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
